keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_pkg.sv | 85 ++++++++
 rtl/keypad_emulator.sv | 165 ++++++++++++++++
 tb/tb_keypad_emulator.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared key map for the 4x4 matrix keypad. Used by the keypad emulator and by
// the scanner so both sides agree on which (row, col) pair each key occupies.
//
// Layout (row/col encodings are one-hot, MSB = row0 / col0):
//             col0  col1  col2  col3
//   row0       1     2     3     A
//   row1       4     5     6     B
//   row2       7     8     9     C
//   row3       *     0     #     D
//
// Contents:
//   kp_state_e      emulator FSM states
//   KEY_*           4-bit key codes (0x0-0x9 digits, 0xA-0xD letters, 0xE '*', 0xF '#')
//   ROW_* / COL_*   one-hot row/column encodings
//   rowcol_t        packed {row, col} pair
//   key_to_rowcol   key code -> {row, col}
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } kp_state_e;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam logic [3:0] ROW_0 = 4'b1000;
  localparam logic [3:0] ROW_1 = 4'b0100;
  localparam logic [3:0] ROW_2 = 4'b0010;
  localparam logic [3:0] ROW_3 = 4'b0001;

  localparam logic [3:0] COL_0 = 4'b1000;
  localparam logic [3:0] COL_1 = 4'b0100;
  localparam logic [3:0] COL_2 = 4'b0010;
  localparam logic [3:0] COL_3 = 4'b0001;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } rowcol_t;

  function automatic rowcol_t key_to_rowcol(input logic [3:0] key_code);
    rowcol_t rc;
    rc.row = ROW_3;
    rc.col = COL_3;
    case (key_code)
      KEY_1:    begin rc.row = ROW_0; rc.col = COL_0; end
      KEY_2:    begin rc.row = ROW_0; rc.col = COL_1; end
      KEY_3:    begin rc.row = ROW_0; rc.col = COL_2; end
      KEY_A:    begin rc.row = ROW_0; rc.col = COL_3; end
      KEY_4:    begin rc.row = ROW_1; rc.col = COL_0; end
      KEY_5:    begin rc.row = ROW_1; rc.col = COL_1; end
      KEY_6:    begin rc.row = ROW_1; rc.col = COL_2; end
      KEY_B:    begin rc.row = ROW_1; rc.col = COL_3; end
      KEY_7:    begin rc.row = ROW_2; rc.col = COL_0; end
      KEY_8:    begin rc.row = ROW_2; rc.col = COL_1; end
      KEY_9:    begin rc.row = ROW_2; rc.col = COL_2; end
      KEY_C:    begin rc.row = ROW_2; rc.col = COL_3; end
      KEY_STAR: begin rc.row = ROW_3; rc.col = COL_0; end
      KEY_0:    begin rc.row = ROW_3; rc.col = COL_1; end
      KEY_HASH: begin rc.row = ROW_3; rc.col = COL_2; end
      default:  begin rc.row = ROW_3; rc.col = COL_3; end  // KEY_D
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
// Emulates a human pressing one key of a 4x4 matrix keypad in front of a
// column-scanning controller. A requested key is held down until the scanner
// has seen it HOLD_MATCHES times (or TIMEOUT_CYCLES have elapsed), then the
// key is released for GAP_CYCLES before another request is taken.
//
// Parameters:
//   HOLD_MATCHES    column-match cycles the key stays pressed
//   GAP_CYCLES      release cycles after each key
//   TIMEOUT_CYCLES  maximum cycles spent in PRESS
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   en         enable; low freezes FSM/counters and forces row to 0000
//   key_valid  key request strobe
//   key_code   key to press (see keypad_pkg)
//   key_ready  request can be taken this cycle (IDLE and en)
//   col        one-hot column drive from the scanner
//   row        emulated row sense (combinational from col)
//   busy       FSM is not IDLE
//   done       one-cycle pulse: hold count completed, leaving PRESS
//   timeout    one-cycle pulse: timeout expired, leaving PRESS
// -----------------------------------------------------------------------------
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_MATCHES   = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  localparam int MATCH_W = $clog2(HOLD_MATCHES + 1);
  // The cycle counter times the PRESS timeout and, after being cleared, the
  // RELEASE gap, so it is sized for whichever of the two is larger.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Compare against "last value before the limit" so the transition happens
  // on the cycle the count would reach the limit.
  localparam logic [MATCH_W-1:0] HOLD_LAST = MATCH_W'(HOLD_MATCHES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  // With no gap configured the key goes straight back to IDLE.
  localparam kp_state_e AFTER_PRESS = (GAP_CYCLES == 0) ? ST_IDLE : ST_RELEASE;

  kp_state_e          state_reg,      state_next;
  logic [MATCH_W-1:0] match_cnt_reg,  match_cnt_next;
  logic [CNT_W-1:0]   tmo_cnt_reg,    tmo_cnt_next;
  logic [3:0]         target_row_reg, target_row_next;
  logic [3:0]         target_col_reg, target_col_next;

  logic    col_match;
  logic    hold_hit;
  logic    tmo_hit;
  logic    done_int;
  logic    timeout_int;
  rowcol_t decoded;

  assign decoded = key_to_rowcol(key_code);

  // target_col is always one-hot while in PRESS, so equality alone already
  // rejects non-one-hot columns; the zero test keeps that true even for the
  // all-zero column bus.
  assign col_match = (state_reg == ST_PRESS) && (col == target_col_reg) && (col != 4'b0000);
  assign hold_hit  = col_match && (match_cnt_reg == HOLD_LAST);
  assign tmo_hit   = (tmo_cnt_reg == TMO_LAST);

  assign row       = (col_match && en) ? target_row_reg : 4'b0000;
  assign key_ready = (state_reg == ST_IDLE) && en;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_int;
  assign timeout   = timeout_int;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      match_cnt_reg  <= '0;
      tmo_cnt_reg    <= '0;
      target_row_reg <= 4'b0000;
      target_col_reg <= 4'b0000;
    end else begin
      state_reg      <= state_next;
      match_cnt_reg  <= match_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      target_row_reg <= target_row_next;
      target_col_reg <= target_col_next;
    end
  end

  // Next-state and pulse outputs. Everything holds while en is low.
  always_comb begin
    state_next      = state_reg;
    match_cnt_next  = match_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    target_row_next = target_row_reg;
    target_col_next = target_col_reg;
    done_int        = 1'b0;
    timeout_int     = 1'b0;

    if (en) begin
      case (state_reg)
        ST_IDLE: begin
          if (key_valid) begin
            target_row_next = decoded.row;
            target_col_next = decoded.col;
            match_cnt_next  = '0;
            tmo_cnt_next    = '0;
            state_next      = ST_PRESS;
          end
        end

        ST_PRESS: begin
          // Hold completion is checked first so it wins over a
          // simultaneous timeout.
          if (hold_hit) begin
            done_int       = 1'b1;
            match_cnt_next = '0;
            tmo_cnt_next   = '0;
            state_next     = AFTER_PRESS;
          end else if (tmo_hit) begin
            timeout_int    = 1'b1;
            match_cnt_next = '0;
            tmo_cnt_next   = '0;
            state_next     = AFTER_PRESS;
          end else begin
            if (col_match) begin
              match_cnt_next = match_cnt_reg + MATCH_W'(1);
            end
            tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (tmo_cnt_reg == GAP_LAST) begin
            tmo_cnt_next = '0;
            state_next   = ST_IDLE;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// -----------------------------------------------------------------------------
// tb_keypad_emulator
// Directed stimulus with a decoupled scoreboard. The stimulus process pushes
// the expected output events (row/done/timeout, stamped with the cycle they
// must appear in) and status probes (busy/key_ready at a given cycle). The
// monitor samples the DUT on every falling edge, pops and compares.
// -----------------------------------------------------------------------------
module tb_keypad_emulator;

  localparam int HOLD = 2;
  localparam int GAP  = 4;
  localparam int TMO  = 64;
  localparam int WATCHDOG_CYCLES = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] col = 4'b0000;
  logic       key_ready;
  logic [3:0] row;
  logic       busy;
  logic       done;
  logic       timeout;

  keypad_emulator #(
    .HOLD_MATCHES  (HOLD),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .col      (col),
    .row      (row),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] row;
    logic       done;
    logic       tmo;
  } ev_t;

  typedef struct {
    int   cyc;
    logic busy;
    logic ready;
  } probe_t;

  ev_t    out_q[$];
  probe_t probe_q[$];
  int     tests = 0;
  int     fails = 0;
  bit     stim_done = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ev(input int c, input logic [3:0] r, input logic d, input logic t);
    ev_t e;
    e.cyc  = c;
    e.row  = r;
    e.done = d;
    e.tmo  = t;
    out_q.push_back(e);
  endtask

  task automatic exp_probe(input int c, input logic b, input logic r);
    probe_t p;
    p.cyc   = c;
    p.busy  = b;
    p.ready = r;
    probe_q.push_back(p);
  endtask

  // Column pattern for PRESS cycle k (k = 1 is the first cycle after accept).
  // 0: rotating 1000,0100,0010,0001  1: stuck 0001  2: 1100 x3 then 0100
  function automatic logic [3:0] col_for(input int mode, input int k);
    logic [3:0] base;
    base = 4'b1000;
    case (mode)
      0:       return base >> ((k - 1) % 4);
      1:       return 4'b0001;
      2:       return (k <= 3) ? 4'b1100 : 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  // Press one key and queue every expected event from a small behavioural
  // model: match counting, hold completion winning over timeout, fixed gap.
  task automatic press_key(input logic [3:0] key, input logic [3:0] krow,
                           input logic [3:0] kcol, input int mode, input bit poke);
    int         n;
    int         k;
    int         m;
    bit         fin;
    logic [3:0] c;
    step();
    n         = cyc;
    col       = 4'b0000;
    key_code  = key;
    key_valid = 1'b1;
    exp_probe(n, 1'b0, 1'b1);
    k   = 0;
    m   = 0;
    fin = 1'b0;
    while (!fin) begin
      step();
      k++;
      // Optional second request one cycle after accept; must be ignored.
      key_valid = poke && (k == 1);
      key_code  = (poke && (k == 1)) ? 4'h9 : key;
      c   = col_for(mode, k);
      col = c;
      if (c == kcol) m++;
      if (c == kcol && m == HOLD) begin
        exp_ev(n + k, krow, 1'b1, 1'b0);
        fin = 1'b1;
      end else if (k == TMO) begin
        exp_ev(n + k, (c == kcol) ? krow : 4'b0000, 1'b0, 1'b1);
        fin = 1'b1;
      end else if (c == kcol) begin
        exp_ev(n + k, krow, 1'b0, 1'b0);
      end
    end
    key_valid = 1'b0;
    for (int g = 1; g <= GAP; g++) begin
      step();
      col = col_for(mode, k + g);
    end
    exp_probe(n + k + GAP, 1'b1, 1'b0);
    step();
    col = 4'b0000;
    exp_probe(n + k + GAP + 1, 1'b0, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    rst = 1'b0;
    en  = 1'b1;
    step();
    step();
    exp_probe(cyc, 1'b0, 1'b1);         // in reset, key_ready follows en=1
    step();
    en        = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'h7;
    exp_probe(cyc, 1'b0, 1'b0);         // in reset, key_ready follows en=0
    step();
    rst       = 1'b1;
    key_valid = 1'b1;                   // en low: request must be ignored
    exp_probe(cyc, 1'b0, 1'b0);
    step();
    key_valid = 1'b0;
    en        = 1'b1;
    exp_probe(cyc, 1'b0, 1'b1);

    // Single key against rotating columns
    press_key(4'h1, 4'b1000, 4'b1000, 0, 1'b0);
    // Sequence 1,8,6,5
    press_key(4'h1, 4'b1000, 4'b1000, 0, 1'b0);
    press_key(4'h8, 4'b0010, 4'b0100, 0, 1'b0);
    press_key(4'h6, 4'b0100, 4'b0010, 0, 1'b0);
    press_key(4'h5, 4'b0100, 4'b0100, 0, 1'b0);
    // Column never matches: timeout
    press_key(4'h1, 4'b1000, 4'b1000, 1, 1'b0);
    // Non-one-hot column then the right one
    press_key(4'h5, 4'b0100, 4'b0100, 2, 1'b0);
    // Second request while busy is dropped
    press_key(4'h2, 4'b1000, 4'b0100, 0, 1'b1);
    // Bottom row and column-3 keys
    press_key(4'hF, 4'b0001, 4'b0010, 0, 1'b0);
    press_key(4'hD, 4'b0001, 4'b0001, 0, 1'b0);
    press_key(4'h0, 4'b0001, 4'b0100, 0, 1'b0);
    press_key(4'hE, 4'b0001, 4'b1000, 0, 1'b0);
    press_key(4'hA, 4'b1000, 4'b0001, 0, 1'b0);

    // en dropped mid-PRESS: row forced low, counters frozen, no done
    step();
    n         = cyc;
    col       = 4'b0000;
    key_code  = 4'h5;
    key_valid = 1'b1;
    exp_probe(n, 1'b0, 1'b1);
    step();
    key_valid = 1'b0;
    col       = 4'b0100;
    exp_ev(n + 1, 4'b0100, 1'b0, 1'b0);
    step();
    en = 1'b0;
    exp_probe(n + 2, 1'b1, 1'b0);
    step();
    exp_probe(n + 3, 1'b1, 1'b0);
    step();
    en = 1'b1;
    exp_ev(n + 4, 4'b0100, 1'b1, 1'b0);
    for (int g = 1; g <= GAP; g++) begin
      step();
      col = 4'b0000;
    end
    exp_probe(n + 4 + GAP, 1'b1, 1'b0);
    step();
    exp_probe(n + 5 + GAP, 1'b0, 1'b1);

    // Reset dropped mid-PRESS with a matching column: row must clear at once
    step();
    n         = cyc;
    col       = 4'b0000;
    key_code  = 4'h5;
    key_valid = 1'b1;
    exp_probe(n, 1'b0, 1'b1);
    step();
    key_valid = 1'b0;
    col       = 4'b0000;
    step();
    col = 4'b0100;
    #1;
    rst = 1'b0;
    exp_probe(n + 2, 1'b0, 1'b1);
    step();
    rst = 1'b1;
    col = 4'b0000;
    exp_probe(n + 3, 1'b0, 1'b1);

    // Operation resumes after reset
    press_key(4'h3, 4'b1000, 4'b0010, 0, 1'b0);

    step();
    stim_done = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    ev_t    e;
    probe_t p;
    while (!stim_done) begin
      @(negedge clk);
      if (cyc > WATCHDOG_CYCLES) begin
        tests++;
        fails++;
        $display("FAIL watchdog: cycle %0d exceeded limit %0d", cyc, WATCHDOG_CYCLES);
        break;
      end
      while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
        p = probe_q.pop_front();
        tests++;
        if (p.cyc != cyc || busy !== p.busy || key_ready !== p.ready) begin
          fails++;
          $display("FAIL status cyc=%0d: busy=%b key_ready=%b, required busy=%b key_ready=%b at cyc %0d",
                   cyc, busy, key_ready, p.busy, p.ready, p.cyc);
        end
      end
      while (out_q.size() > 0 && out_q[0].cyc < cyc) begin
        e = out_q.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_output cyc=%0d: nothing seen, required row=%b done=%b timeout=%b",
                 e.cyc, e.row, e.done, e.tmo);
      end
      if (row !== 4'b0000 || done !== 1'b0 || timeout !== 1'b0) begin
        tests++;
        if (out_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output cyc=%0d: row=%b done=%b timeout=%b, required none",
                   cyc, row, done, timeout);
        end else begin
          e = out_q.pop_front();
          if (e.cyc != cyc || row !== e.row || done !== e.done || timeout !== e.tmo) begin
            fails++;
            $display("FAIL output cyc=%0d: row=%b done=%b timeout=%b, required row=%b done=%b timeout=%b at cyc %0d",
                     cyc, row, done, timeout, e.row, e.done, e.tmo, e.cyc);
          end else begin
            $display("[TB] cyc=%0d row=%b done=%b timeout=%b ok", cyc, row, done, timeout);
          end
        end
      end
    end
    while (out_q.size() > 0) begin
      e = out_q.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_output cyc=%0d: nothing seen, required row=%b done=%b timeout=%b",
               e.cyc, e.row, e.done, e.tmo);
    end
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      tests++;
      fails++;
      $display("FAIL status_unchecked cyc=%0d: never sampled, required busy=%b key_ready=%b",
               p.cyc, p.busy, p.ready);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
